// File: rtl/huffman_code_gen_if.sv
// Handshake and result bundle between the sort stage, the Huffman code
// generator and the downstream encoder.
interface huffman_code_gen_if;
    logic        start;
    logic [31:0] SORT_RESULT;
    logic        busy;
    logic        done;
    logic        err;
    logic [11:0] CODE_OUT;
    logic [7:0]  LEN_OUT;
    logic [5:0]  ROOT_W;

    modport master (
        output start, SORT_RESULT,
        input  busy, done, err, CODE_OUT, LEN_OUT, ROOT_W
    );

    modport slave (
        input  start, SORT_RESULT,
        output busy, done, err, CODE_OUT, LEN_OUT, ROOT_W
    );
endinterface

// File: rtl/huffman_code_gen.sv
// Builds the 4-symbol Huffman tree from an ascending weight list, one merge
// per clock, and publishes per-symbol codewords, code lengths and root weight.
module huffman_code_gen (
    input  logic              CLK,
    input  logic              nRST,
    huffman_code_gen_if.slave bus
);
    // state   | meaning
    // S_IDLE  | waiting for start; captures and validates SORT_RESULT
    // S_MERGE | three merge steps, r_cnt 0..2
    // S_DONE  | one-cycle done pulse, results (or err) visible
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MERGE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic        w_accept;
    logic        w_invalid;

    logic [1:0]  r_cnt;
    logic [5:0]  r_w    [4];
    logic [3:0]  r_m    [4];
    logic [2:0]  r_code [4];
    logic [1:0]  r_len  [4];

    logic [11:0] r_code_out;
    logic [7:0]  r_len_out;
    logic [5:0]  r_root;
    logic        r_err;

    logic [3:0]  w_id [4];
    logic [3:0]  w_fq [4];

    logic [5:0]  w_sum;
    logic [3:0]  w_mask;
    logic [1:0]  w_rem;
    logic [1:0]  w_pos;
    logic [5:0]  w_nw      [4];
    logic [3:0]  w_nm      [4];
    logic [2:0]  w_code_nx [4];
    logic [1:0]  w_len_nx  [4];

    always_comb begin
        w_invalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_id[i] = bus.SORT_RESULT[8*i +: 4];
            w_fq[i] = bus.SORT_RESULT[8*i+4 +: 4];
        end
        for (int i = 0; i < 4; i++) begin
            if (w_id[i] > 4'd3) w_invalid = 1'b1;
            for (int j = i + 1; j < 4; j++) begin
                if (w_id[i] == w_id[j]) w_invalid = 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (w_fq[i] > w_fq[i+1]) w_invalid = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept   = 1'b1;
                    w_state_nx = w_invalid ? S_DONE : S_MERGE;
                end
            end
            S_MERGE: begin
                if (r_cnt == 2'd2) w_state_nx = S_DONE;
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Merge of the two lightest nodes; the new node lands after every remaining
    // entry of equal or lower weight, so ties keep the merged node last.
    always_comb begin
        w_sum  = r_w[0] + r_w[1];
        w_mask = r_m[0] | r_m[1];
        w_rem  = 2'd2 - r_cnt;
        w_pos  = 2'd0;
        for (int j = 0; j < 2; j++) begin
            if ((2'(j) < w_rem) && (r_w[j+2] <= w_sum)) w_pos = w_pos + 2'd1;
        end
        for (int i = 0; i < 4; i++) begin
            w_nw[i] = 6'd0;
            w_nm[i] = 4'd0;
        end
        for (int i = 0; i < 2; i++) begin
            if (2'(i) < w_pos) begin
                w_nw[i] = r_w[i+2];
                w_nm[i] = r_m[i+2];
            end
        end
        for (int i = 1; i < 3; i++) begin
            if (2'(i) > w_pos) begin
                w_nw[i] = r_w[i+1];
                w_nm[i] = r_m[i+1];
            end
        end
        w_nw[w_pos] = w_sum;
        w_nm[w_pos] = w_mask;

        for (int s = 0; s < 4; s++) begin
            w_code_nx[s] = r_code[s];
            w_len_nx[s]  = r_len[s];
            if (r_m[1][s]) w_code_nx[s] = r_code[s] | (3'b001 << r_len[s]);
            if (r_m[0][s] | r_m[1][s]) w_len_nx[s] = r_len[s] + 2'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_cnt      <= 2'd0;
            r_code_out <= 12'd0;
            r_len_out  <= 8'd0;
            r_root     <= 6'd0;
            r_err      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_w[i]    <= 6'd0;
                r_m[i]    <= 4'd0;
                r_code[i] <= 3'd0;
                r_len[i]  <= 2'd0;
            end
        end else if (w_accept) begin
            if (w_invalid) begin
                r_err      <= 1'b1;
                r_code_out <= 12'd0;
                r_len_out  <= 8'd0;
                r_root     <= 6'd0;
            end else begin
                r_cnt <= 2'd0;
                for (int i = 0; i < 4; i++) begin
                    r_w[i]    <= {2'b00, w_fq[i]};
                    r_m[i]    <= 4'b0001 << w_id[i][1:0];
                    r_code[i] <= 3'd0;
                    r_len[i]  <= 2'd0;
                end
            end
        end else if (r_state == S_MERGE) begin
            r_cnt <= r_cnt + 2'd1;
            for (int i = 0; i < 4; i++) begin
                r_w[i]    <= w_nw[i];
                r_m[i]    <= w_nm[i];
                r_code[i] <= w_code_nx[i];
                r_len[i]  <= w_len_nx[i];
            end
            if (r_cnt == 2'd2) begin
                r_code_out <= {w_code_nx[3], w_code_nx[2], w_code_nx[1], w_code_nx[0]};
                r_len_out  <= {w_len_nx[3], w_len_nx[2], w_len_nx[1], w_len_nx[0]};
                r_root     <= w_sum;
                r_err      <= 1'b0;
            end
        end
    end

    assign bus.busy     = (r_state == S_MERGE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.err      = r_err;
    assign bus.CODE_OUT = r_code_out;
    assign bus.LEN_OUT  = r_len_out;
    assign bus.ROOT_W   = r_root;
endmodule

// File: tb/tb_huffman_code_gen.sv
// Scoreboard bench for huffman_code_gen: directed vectors push expected
// results; a negedge monitor pops and compares on every done pulse.
module tb_huffman_code_gen;
    logic CLK;
    logic nRST;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    huffman_code_gen_if bus ();

    huffman_code_gen dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct {
        logic [11:0] code;
        logic [7:0]  len;
        logic [5:0]  root;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (nRST === 1'b1 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("code_out",   32'(bus.CODE_OUT), 32'(e.code));
                chk("len_out",    32'(bus.LEN_OUT),  32'(e.len));
                chk("root_w",     32'(bus.ROOT_W),   32'(e.root));
                chk("err",        32'(bus.err),      32'(e.err));
                chk("busy_at_done", 32'(bus.busy),   32'd0);
            end
        end
    end

    task automatic push(input logic [11:0] code, input logic [7:0] len,
                        input logic [5:0] root, input logic err, input int at);
        exp_t e;
        e.code = code;
        e.len  = len;
        e.root = root;
        e.err  = err;
        e.cyc  = at;
        sb_q.push_back(e);
    endtask

    // Called just after a rising edge; start is sampled on the next edge.
    task automatic issue_start(input logic [31:0] sr);
        bus.SORT_RESULT = sr;
        bus.start       = 1'b1;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic run_valid(input logic [31:0] sr, input logic [11:0] code,
                             input logic [7:0] len, input logic [5:0] root);
        push(code, len, root, 1'b0, cyc + 4);
        issue_start(sr);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("busy_merge", 32'(bus.busy), 32'd1);
        end
        @(negedge CLK);
        chk("busy_after_merge", 32'(bus.busy), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic run_invalid(input logic [31:0] sr);
        push(12'd0, 8'd0, 6'd0, 1'b1, cyc + 1);
        issue_start(sr);
        @(negedge CLK);
        chk("busy_invalid", 32'(bus.busy), 32'd0);
        @(negedge CLK);
        chk("done_drop_invalid", 32'(bus.done), 32'd0);
        chk("busy_invalid_2", 32'(bus.busy), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy),     32'd0);
        chk({tag, "_done"}, 32'(bus.done),     32'd0);
        chk({tag, "_err"},  32'(bus.err),      32'd0);
        chk({tag, "_code"}, 32'(bus.CODE_OUT), 32'd0);
        chk({tag, "_len"},  32'(bus.LEN_OUT),  32'd0);
        chk({tag, "_root"}, 32'(bus.ROOT_W),   32'd0);
    endtask

    initial begin
        repeat (2000) @(posedge CLK);
        $display("FAIL watchdog: run did not finish, got %0d cycles, expected under 2000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        n_cmp           = 0;
        n_bad           = 0;
        nRST            = 1'b0;
        bus.start       = 1'b0;
        bus.SORT_RESULT = 32'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_all_zero("reset");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        // A=110 B=111 C=010 D=000, lengths 3,3,2,1
        run_valid(32'h43322110, 12'h0BE, 8'h6F, 6'd10);
        // all equal: 00,01,10,11, lengths 2
        run_valid(32'h13121110, 12'h688, 8'hAA, 6'd4);
        run_valid(32'h03020100, 12'h688, 8'hAA, 6'd0);
        // ties 1,1,2,3: merged AB sorts after C, same tree as the distinct case
        run_valid(32'h33221110, 12'h0BE, 8'h6F, 6'd7);

        run_invalid(32'h10213243);
        run_invalid(32'h33211010);
        run_invalid(32'h43322114);

        run_valid(32'h43322110, 12'h0BE, 8'h6F, 6'd10);

        // start held high: second run begins on the first IDLE cycle
        c = cyc;
        push(12'h688, 8'hAA, 6'd4, 1'b0, c + 4);
        push(12'h0BE, 8'h6F, 6'd10, 1'b0, c + 9);
        bus.SORT_RESULT = 32'h13121110;
        bus.start       = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        bus.SORT_RESULT = 32'h43322110;
        repeat (4) @(posedge CLK);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        chk("held_start_runs", 32'(sb_q.size()), 32'd0);

        // reset after the first merge wipes held results
        issue_start(32'h13121110);
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk_all_zero("midrun_reset");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        run_valid(32'h43322110, 12'h0BE, 8'h6F, 6'd10);

        repeat (3) @(posedge CLK);
        #1;
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
